// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the sync_fifo slice.
package sync_fifo_pkg;
    localparam int unsigned FIFO_WIDTH_DEF     = 8;
    localparam int unsigned FIFO_ADR_WIDTH_DEF = 3;
endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Kept separate so it can later be swapped for a RAM primitive.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FIFO_WIDTH_DEF,
    parameter int unsigned ADR_WIDTH = FIFO_ADR_WIDTH_DEF,
    parameter int unsigned DEPTH     = 2 ** ADR_WIDTH
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy counter and full/empty flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FIFO_WIDTH_DEF,
    parameter int unsigned ADR_WIDTH = FIFO_ADR_WIDTH_DEF,
    parameter int unsigned DEPTH     = 2 ** ADR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int unsigned CNT_WIDTH = ADR_WIDTH + 1;

    logic [ADR_WIDTH-1:0] wr_ptr;
    logic [ADR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 wr_acc;
    logic                 rd_acc;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    assign wr_acc = wr_en && (!full || rd_en);
    assign rd_acc = rd_en && !empty;

    assign empty = (count == '0);
    assign full  = (count == CNT_WIDTH'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADR_WIDTH'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(
        .WIDTH     (WIDTH),
        .ADR_WIDTH (ADR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed plan followed by randomized traffic.
module tb_sync_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       empty;
    logic       full;

    int  checks = 0;
    int  errors = 0;
    bit  armed  = 1'b0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue updated by the acceptance rules on every rising edge.
    always @(posedge clk) begin
        bit rd_ok;
        bit wr_ok;
        if (rst) begin
            exp_q.delete();
        end else begin
            rd_ok = rd_en && (exp_q.size() > 0);
            wr_ok = wr_en && ((exp_q.size() < DEPTH) || rd_en);
            if (rd_ok) void'(exp_q.pop_front());
            if (wr_ok) exp_q.push_back(data_in);
        end
    end

    // Monitor: compare flags, occupancy and the visible head word away from the edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("count", 32'(dut.count), 32'(exp_q.size()));
            chk("empty", 32'(empty), 32'(exp_q.size() == 0));
            chk("full",  32'(full),  32'(exp_q.size() == DEPTH));
            if (exp_q.size() > 0) begin
                chk("head", 32'(data_out), 32'(exp_q[0]));
            end
        end
    end

    task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit rs);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        rst     = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] v;
        // Reset for two cycles, then a read on the empty FIFO.
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        armed = 1'b1;
        chk("rst_count", 32'(dut.count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("rd_empty_count", 32'(dut.count), 32'd0);

        // Fill 0x11..0x88 on alternate cycles, then a dropped 9th write.
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i * 8'h11);
            cyc(1'b1, 1'b0, v, 1'b0);
            chk("fill_count", 32'(dut.count), 32'(i));
            idle();
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b0, 8'h99, 1'b0);
        chk("drop_count", 32'(dut.count), 32'd8);
        chk("drop_head",  32'(data_out), 32'h11);

        // Drain on alternate cycles; head word checked by the monitor before every read.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            idle();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("overdrain_count", 32'(dut.count), 32'd0);

        // Wrap: 5 in/5 out, then 6 in/6 out.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'(8'hB0 + i), 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("wrap_count", 32'(dut.count), 32'd0);

        // Simultaneous at empty, at count 3 and at full.
        cyc(1'b1, 1'b1, 8'hC0, 1'b0);
        chk("sim_empty_count", 32'(dut.count), 32'd1);
        cyc(1'b1, 1'b0, 8'hC1, 1'b0);
        cyc(1'b1, 1'b0, 8'hC2, 1'b0);
        cyc(1'b1, 1'b1, 8'hC3, 1'b0);
        chk("sim_3_count", 32'(dut.count), 32'd3);
        chk("sim_3_head",  32'(data_out), 32'hC1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hD0 + i), 1'b0);
        chk("sim_pre_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("sim_full_count", 32'(dut.count), 32'd8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);

        // Mid-operation reset together with a write.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
        chk("pre_rst_count", 32'(dut.count), 32'd5);
        cyc(1'b1, 1'b0, 8'h77, 1'b1);
        chk("midrst_count", 32'(dut.count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);

        // Randomized traffic with shifting read/write bias and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int wp;
            int rp;
            wp = ((i / 300) % 2 == 0) ? 70 : 35;
            rp = 100 - wp;
            cyc(bit'($urandom_range(0, 99) < wp), bit'($urandom_range(0, 99) < rp),
                8'($urandom), bit'($urandom_range(0, 249) == 0));
        end
        idle();

        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sync_fifo
